// File: rtl/cpu_pkg.sv
// Shared CPU definitions for register-file writeback: widths, zero register,
// writeback request payload and requester port indices.
package cpu_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam int unsigned WB_PORT_ALU = 0;
    localparam int unsigned WB_PORT_MEM = 1;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the two writeback requesters (ALU, memory) and the
// register-file writeback arbiter, including the register-file write side.
interface regfile_wb_arbiter_if
    import cpu_pkg::*;
#(
    parameter int unsigned AW = REG_AW,
    parameter int unsigned DW = REG_DW
) ();

    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;

    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;

    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_wren;
    logic          wb_busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_waddr, rf_wdata, rf_wren, wb_busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_waddr, rf_wdata, rf_wren, wb_busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational and one-hot; the
// last winner is remembered only when the caller reports an accepted grant.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_last_grant;

    // Conflicts go to the port that did not win last; nothing is granted in reset.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (advance) begin
            r_last_grant <= gnt[WB_PORT_MEM];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding a one-entry stage that drives the
// register-file write port. Define REGFILE_WB_BYPASS_EN to add read forwarding.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW = REG_AW,
    parameter int unsigned DW = REG_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_wb_arbiter_if.slave bus
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    input  logic [DW-1:0] rf_rdata0,
    input  logic [DW-1:0] rf_rdata1,
    output logic [DW-1:0] fwd_rdata0,
    output logic [DW-1:0] fwd_rdata1
`endif
);

    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_advance;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_data;

    logic          r_wren;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;

    assign w_req     = {bus.req1_valid, bus.req0_valid};
    assign w_advance = |w_gnt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_advance),
        .gnt     (w_gnt)
    );

    assign bus.req0_ready = w_gnt[WB_PORT_ALU];
    assign bus.req1_ready = w_gnt[WB_PORT_MEM];

    assign w_win_addr = w_gnt[WB_PORT_MEM] ? bus.req1_addr : bus.req0_addr;
    assign w_win_data = w_gnt[WB_PORT_MEM] ? bus.req1_data : bus.req0_data;

    // Writes to the zero register are accepted but never reach the file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wren  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_advance) begin
            r_wren  <= (w_win_addr != AW'(REG_ZERO));
            r_waddr <= w_win_addr;
            r_wdata <= w_win_data;
        end else begin
            r_wren  <= 1'b0;
        end
    end

    assign bus.rf_wren  = r_wren;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;
    assign bus.wb_busy  = r_wren;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight write so readers need not stall on wb_busy.
    always_comb begin
        fwd_rdata0 = rf_rdata0;
        fwd_rdata1 = rf_rdata1;
        if (r_wren && (r_waddr == rd_addr0) && (rd_addr0 != AW'(REG_ZERO))) begin
            fwd_rdata0 = r_wdata;
        end
        if (r_wren && (r_waddr == rd_addr1) && (rd_addr1 != AW'(REG_ZERO))) begin
            fwd_rdata1 = r_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a transaction-level model with
// a per-cycle compare process, plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;
    import cpu_pkg::*;

    localparam int unsigned AW = REG_AW;
    localparam int unsigned DW = REG_DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    regfile_wb_arbiter_if #(.AW(AW), .DW(DW)) u_if ();

`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [DW-1:0] rf_rdata0, rf_rdata1, fwd_rdata0, fwd_rdata1;
`endif

    regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rf_rdata0  (rf_rdata0),
        .rf_rdata1  (rf_rdata1),
        .fwd_rdata0 (fwd_rdata0),
        .fwd_rdata1 (fwd_rdata1)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which port should win: -1 none, else port index.
    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return 1 - last;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    // Model state: pending write, round-robin memory, register contents, grant history.
    int            m_last = 1;
    logic          m_wren = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rf [32];
    int            grant_log [$];
    bit            m_live = 1'b0;
    int            m_pick;
    int            c_pick;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wren  = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_last  = 1;
        end else begin
            if (m_wren) m_rf[m_waddr] = m_wdata;
            m_pick = pick(u_if.req0_valid, u_if.req1_valid, m_last);
            if (m_pick == 0) begin
                m_waddr = u_if.req0_addr;
                m_wdata = u_if.req0_data;
            end else if (m_pick == 1) begin
                m_waddr = u_if.req1_addr;
                m_wdata = u_if.req1_data;
            end
            m_wren = (m_pick >= 0) && (m_waddr != 0);
            if (m_pick >= 0) begin
                m_last = m_pick;
                grant_log.push_back(m_pick);
            end
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            c_pick = pick(u_if.req0_valid, u_if.req1_valid, m_last);
            chk("req0_ready", DW'(u_if.req0_ready), DW'(rst_n && c_pick == 0));
            chk("req1_ready", DW'(u_if.req1_ready), DW'(rst_n && c_pick == 1));
            chk("rf_wren",    DW'(u_if.rf_wren),    DW'(m_wren));
            chk("rf_waddr",   DW'(u_if.rf_waddr),   DW'(m_waddr));
            chk("rf_wdata",   u_if.rf_wdata,        m_wdata);
            chk("wb_busy",    DW'(u_if.wb_busy),    DW'(m_wren));
`ifdef REGFILE_WB_BYPASS_EN
            chk("fwd_rdata0", fwd_rdata0,
                (m_wren && m_waddr == rd_addr0 && rd_addr0 != 0) ? m_wdata : rf_rdata0);
            chk("fwd_rdata1", fwd_rdata1,
                (m_wren && m_waddr == rd_addr1 && rd_addr1 != 0) ? m_wdata : rf_rdata1);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input wb_req_t r0, input wb_req_t r1);
        u_if.req0_valid = r0.valid;
        u_if.req0_addr  = r0.addr;
        u_if.req0_data  = r0.data;
        u_if.req1_valid = r1.valid;
        u_if.req1_addr  = r1.addr;
        u_if.req1_data  = r1.data;
    endtask

    wb_req_t tv0 [6] = '{
        '{1'b1, 5'd10, 32'hA1}, '{1'b0, 5'd0, 32'h0}, '{1'b1, 5'd0, 32'hA3},
        '{1'b1, 5'd14, 32'hA4}, '{1'b0, 5'd0, 32'h0}, '{1'b1, 5'd20, 32'hA6}};
    wb_req_t tv1 [6] = '{
        '{1'b1, 5'd11, 32'hB1}, '{1'b1, 5'd12, 32'hB2}, '{1'b1, 5'd13, 32'hB3},
        '{1'b0, 5'd0, 32'h0},   '{1'b0, 5'd0, 32'h0},   '{1'b1, 5'd21, 32'hB6}};

    wb_req_t idle = '{1'b0, 5'd0, 32'h0};
    logic [AW-1:0] exp_seq [4] = '{5'd3, 5'd7, 5'd3, 5'd7};
    int n;

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
`ifdef REGFILE_WB_BYPASS_EN
        rd_addr0 = '0; rd_addr1 = '0; rf_rdata0 = '0; rf_rdata1 = '0;
`endif
        // Reset held with both ports requesting
        rst_n = 1'b0;
        drive('{1'b1, 5'd1, 32'h0A}, '{1'b1, 5'd2, 32'h0B});
        repeat (3) step();
        peek();
        chk("rst_ready0", DW'(u_if.req0_ready), DW'(0));
        chk("rst_ready1", DW'(u_if.req1_ready), DW'(0));
        chk("rst_wren",   DW'(u_if.rf_wren),    DW'(0));
        chk("rst_waddr",  DW'(u_if.rf_waddr),   DW'(0));
        chk("rst_wdata",  u_if.rf_wdata,        DW'(0));
        chk("rst_busy",   DW'(u_if.wb_busy),    DW'(0));
        rst_n = 1'b1;
        #1;
        chk("first_conflict_ready0", DW'(u_if.req0_ready), DW'(1));
        chk("first_conflict_ready1", DW'(u_if.req1_ready), DW'(0));
        step();
        drive(idle, idle);
        repeat (2) step();

        // Zero-register write from port 1
        drive(idle, '{1'b1, 5'd0, 32'h1234});
        #1;
        chk("zero_ready1", DW'(u_if.req1_ready), DW'(1));
        step();
        drive(idle, idle);
        peek();
        chk("zero_wren", DW'(u_if.rf_wren), DW'(0));
        chk("zero_busy", DW'(u_if.wb_busy), DW'(0));
        step();

        // Continuous conflict alternates 0,1,0,1
        drive('{1'b1, 5'd3, 32'h300}, '{1'b1, 5'd7, 32'h700});
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) drive(idle, idle);
            peek();
            chk("conflict_waddr", DW'(u_if.rf_waddr), DW'(exp_seq[i]));
        end
        n = grant_log.size();
        for (int i = 0; i < 4; i++) begin
            chk("model_grant_order", DW'(grant_log[n - 4 + i]), DW'(i % 2));
        end
        step();

        // Same address on both ports: port 0 first, port 1 data survives
        drive('{1'b1, 5'd9, 32'h11}, '{1'b1, 5'd9, 32'h22});
        step();
        u_if.req0_valid = 1'b0;
        peek();
        chk("same_addr_first", u_if.rf_wdata, DW'(32'h11));
        step();
        u_if.req1_valid = 1'b0;
        peek();
        chk("same_addr_second", u_if.rf_wdata, DW'(32'h22));
        repeat (2) step();
        chk("model_rf9_final", m_rf[9], DW'(32'h22));

        // Single write from port 0
        drive('{1'b1, 5'd5, 32'hDEADBEEF}, idle);
        #1;
        chk("single_ready0", DW'(u_if.req0_ready), DW'(1));
        step();
        drive(idle, idle);
        peek();
        chk("single_wren",  DW'(u_if.rf_wren),  DW'(1));
        chk("single_waddr", DW'(u_if.rf_waddr), DW'(5));
        chk("single_wdata", u_if.rf_wdata,      DW'(32'hDEADBEEF));
        chk("single_busy",  DW'(u_if.wb_busy),  DW'(1));
        step();
        peek();
        chk("single_drain_wren", DW'(u_if.rf_wren), DW'(0));

        // Mixed directed vectors, checked by the model each cycle
        for (int i = 0; i < 6; i++) begin
            drive(tv0[i], tv1[i]);
            step();
        end

        // Reset asserted with a write in flight and requests pending
        drive('{1'b1, 5'd12, 32'hC0C0}, '{1'b1, 5'd13, 32'hD0D0});
        rst_n = 1'b0;
        #1;
        chk("midrst_ready0", DW'(u_if.req0_ready), DW'(0));
        chk("midrst_ready1", DW'(u_if.req1_ready), DW'(0));
        step();
        peek();
        chk("midrst_wren", DW'(u_if.rf_wren), DW'(0));
        rst_n = 1'b1;
        drive(idle, idle);
        repeat (2) step();

`ifdef REGFILE_WB_BYPASS_EN
        drive('{1'b1, 5'd4, 32'hAA}, idle);
        step();
        drive(idle, idle);
        rd_addr0 = 5'd4; rf_rdata0 = 32'h55;
        rd_addr1 = 5'd4; rf_rdata1 = 32'h66;
        peek();
        chk("bypass_fwd0", fwd_rdata0, DW'(32'hAA));
        chk("bypass_fwd1", fwd_rdata1, DW'(32'hAA));
        rd_addr0 = 5'd0;
        #1;
        chk("bypass_zero_raw", fwd_rdata0, DW'(32'h55));
        step();
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 is ALU/execute writeback, port 1 is load/memory writeback.
- Arbitrates round-robin and registers the winner into a one-entry writeback stage.
- The stage drives waddr/wdata/wren of the 32x32 register file (1 write, 2 async reads).
- Register 0 is hardwired zero: writes to it are accepted and discarded.

Parameters:
- AW, 5, register address width (32 registers)
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  port 0 write request
- req0_ready  out  1  port 0 granted this cycle (combinational)
- req0_addr  in  AW  port 0 destination register
- req0_data  in  DW  port 0 write data
- req1_valid  in  1  port 1 write request
- req1_ready  out  1  port 1 granted this cycle (combinational)
- req1_addr  in  AW  port 1 destination register
- req1_data  in  DW  port 1 write data
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- rf_wren  out  1  register-file write enable (registered)
- wb_busy  out  1  writeback stage holds a nonzero-address write landing at the next edge

Behaviour:
- Reset (rst_n=0 at an edge):
  - rf_wren=0, rf_waddr=0, rf_wdata=0, wb_busy=0.
  - Round-robin pointer last_grant=1, so port 0 wins the first conflict.
- The register file always accepts writes, so the stage drains every cycle and there is no backpressure from downstream.
- Grant (combinational):
  - Only one valid: that port is granted.
  - Both valid: grant the port != last_grant.
  - Neither valid: no grant.
  - reqN_ready=1 only for the granted port.
  - A handshake is valid&&ready at a rising edge.
  - The ready outputs must not depend on the ready inputs of other blocks (no combinational loop).
- On an edge with a grant:
  - Stage captures addr/data of the winner.
  - rf_wren <= (addr != 0).
  - last_grant <= winner.
- On an edge with no grant: rf_wren <= 0; rf_waddr/rf_wdata hold their values; last_grant holds.
- Latency: exactly 1 cycle from accepted request to rf_wren high; the register file updates at the following edge.
- Throughput: 1 write/cycle.
- Fairness: a valid request waits at most 1 cycle while the other port is continuously valid.
- Requester rule: addr/data must stay stable while valid && !ready; the arbiter does not latch un-granted requests.
- Same nonzero address on both ports in the same cycle: both writes happen in grant order; the later grant's data is the final register value.
- addr=0: the handshake completes normally; rf_wren=0 in the following cycle; wb_busy=0.
- wb_busy = rf_wren. The hazard unit uses it to stall reads of rf_waddr.
- Reset during operation: the stage contents are discarded; no write occurs at the edge following reset assertion; a request pending in that cycle is not acknowledged.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- With the macro defined, add these ports:
  - rd_addr0/rd_addr1  in  AW  register-file read addresses
  - rf_rdata0/rf_rdata1  in  DW  raw register-file read data
  - fwd_rdata0/fwd_rdata1  out  DW  forwarded read data
- Forwarding rule: fwd_rdataN = (rf_wren && rf_waddr==rd_addrN && rd_addrN!=0) ? rf_wdata : rf_rdataN, purely combinational.
- Address 0 always yields the raw value.
- With the macro undefined, these ports and this logic are absent and consumers must stall on wb_busy.

Decomposition:
- Shared package cpu_pkg:
  - REG_AW=5 and REG_DW=32.
  - REG_ZERO=5'd0.
  - Writeback request struct {valid, addr, data}.
  - Port index constants WB_PORT_ALU=0 and WB_PORT_MEM=1.
- One sub-module, rr_arb2: 2-input round-robin arbiter holding last_grant. Inputs: clk, rst_n, req[1:0], advance. Output: one-hot gnt[1:0].
- Top level holds the stage register and the optional bypass.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valid -> rf_wren=0, both ready=0 after the reset edge, rf_waddr=0, rf_wdata=0; after release, the first conflict grants port 0.
- Single write: req0 {addr=5, data=0xDEADBEEF} for 1 cycle -> req0_ready=1; next cycle rf_wren=1, rf_waddr=5, rf_wdata=0xDEADBEEF, wb_busy=1; one cycle later rf_wren=0.
- Continuous conflict: both valid for 4 cycles, port 0 addr=3, port 1 addr=7 -> grants alternate 0,1,0,1; rf_waddr sequence is 3,7,3,7.
- Zero register: req1 {addr=0, data=0x1234} -> req1_ready=1; next cycle rf_wren=0, wb_busy=0.
- Same address, both ports: port 0 data=0x11 and port 1 data=0x22 to addr=9, last_grant=1 -> 0x11 written, then 0x22; final register value is 0x22.
- Bypass (REGFILE_WB_BYPASS_EN): rf_wren=1, rf_waddr=4, rf_wdata=0xAA, rd_addr0=4, rf_rdata0=0x55 -> fwd_rdata0=0xAA; with rd_addr0=0 -> fwd_rdata0=rf_rdata0.
